// File: rtl/uart_pkg.sv
// Shared types and constants for the transmit-only UART.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/strobe_gen.sv
// Bit-rate clock enable: one-cycle strobe every DIV cycles, phase restarted by i_clear.
// o_pre_strobe fires one cycle ahead so registered outputs can change on the last bit cycle.
module strobe_gen #(
    parameter int unsigned DIV = 868
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_strobe,
    output logic o_pre_strobe
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q, count_d;

    assign o_strobe     = (count_q == CW'(DIV - 1));
    assign o_pre_strobe = (count_q == CW'(DIV - 2));

    always_comb begin
        count_d = count_q + CW'(1);
        if (i_clear || o_strobe) begin
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// Transmit-only 8N1 UART: accepts a byte when idle (or on the last stop-bit cycle) and
// shifts it out LSB first with one bit per BAUD_DIV clocks.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_tx
);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 strobe;
    logic                 pre_strobe;
    logic                 div_clear;

    assign accept    = i_start && !busy_q;
    assign div_clear = accept || (state_q == IDLE);

    strobe_gen #(
        .DIV (BAUD_DIV)
    ) u_strobe_gen (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (div_clear),
        .o_strobe     (strobe),
        .o_pre_strobe (pre_strobe)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        if (accept) begin
            state_d   = START;
            shift_d   = i_data;
            bit_idx_d = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
                START: begin
                    if (strobe) begin
                        state_d   = DATA;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (strobe) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            tx_d      = shift_q[0];
                            shift_d   = shift_q >> 1;
                        end
                    end
                end
                STOP: begin
                    // Drop busy one cycle early so it reads 0 on the last stop-bit cycle.
                    if (pre_strobe) begin
                        busy_d = 1'b0;
                    end
                    if (strobe) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboarded bench: stimulus queues expected bytes, serial monitors decode frames and compare.
module tb_uart_tx_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_a, data_b;
    logic       start_a, start_b;
    logic       busy_a, busy_b;
    logic       tx_a, tx_b;

    int n_vec;
    int n_err;
    int cyc;
    bit mon_en;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    uart_tx_unit #(.BAUD_DIV(4)) u_dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_data    (data_a),
        .i_start   (start_a),
        .o_busy    (busy_a),
        .o_tx      (tx_a)
    );

    uart_tx_unit #(.BAUD_DIV(2)) u_dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_data    (data_b),
        .i_start   (start_b),
        .o_busy    (busy_b),
        .o_tx      (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Called on the negedge where the start bit is first seen; returns on the last stop cycle.
    task automatic decode(input int sel, input int d);
        logic [7:0] b;
        logic [7:0] exp;
        bit stable;
        bit stop_ok;
        stable  = 1'b1;
        stop_ok = 1'b1;
        b       = '0;
        for (int j = 1; j < d; j++) begin
            @(negedge clk);
            if (tx_of(sel) !== 1'b0) stable = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                if (j == 0) b[k] = tx_of(sel);
                else if (tx_of(sel) !== b[k]) stable = 1'b0;
            end
        end
        for (int j = 0; j < d; j++) begin
            @(negedge clk);
            if (tx_of(sel) !== 1'b1) stop_ok = 1'b0;
        end
        if (sel == 0) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_a: got unexpected byte 0x%0h, required no frame", b);
            end else begin
                exp = q_a.pop_front();
                check("frame_a", {24'd0, b}, {24'd0, exp});
            end
        end else begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_b: got unexpected byte 0x%0h, required no frame", b);
            end else begin
                exp = q_b.pop_front();
                check("frame_b", {24'd0, b}, {24'd0, exp});
            end
        end
        check("bit_stable", {31'd0, stable}, 32'd1);
        check("stop_bit", {31'd0, stop_ok}, 32'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_a === 1'b0) decode(0, 4);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_b === 1'b0) decode(1, 2);
        end
    end

    task automatic wait_busy_low(input int sel, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (busy_of(sel) === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: got busy still 1 after %0d cycles, required 0", max);
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, "_tx"}, {31'd0, tx_a}, 32'd1);
            check({name, "_busy"}, {31'd0, busy_a}, 32'd0);
        end
    endtask

    int t0, t1;
    int acc[4];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        data_a  = '0;
        data_b  = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", {31'd0, tx_a}, 32'd1);
        check("rst_busy", {31'd0, busy_a}, 32'd0);

        // 1: asynchronous reset in the middle of a frame of zeros
        @(posedge clk);
        #1 data_a = 8'h00; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("mid_frame_tx", {31'd0, tx_a}, 32'd0);
        check("mid_frame_busy", {31'd0, busy_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx_a}, 32'd1);
        check("async_rst_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("post_rst", 20);
        mon_en = 1'b1;

        // 2: single 0x55, busy profile over the 40 frame cycles
        @(posedge clk);
        #1 data_a = 8'h55; start_a = 1'b1; q_a.push_back(8'h55);
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check("busy_profile", {31'd0, busy_a}, (n < 40) ? 32'd1 : 32'd0);
        end
        check_idle("after_55", 8);

        // 3: start held high, two contiguous frames
        @(posedge clk);
        #1 data_a = 8'h48; start_a = 1'b1; q_a.push_back(8'h48);
        @(posedge clk);
        #1 t0 = cyc; data_a = 8'h65; q_a.push_back(8'h65);
        wait_busy_low(0, 60);
        @(posedge clk);
        #1 t1 = cyc; start_a = 1'b0;
        check("stream_period", t1 - t0, 32'd40);
        @(negedge clk);
        check("stream_no_gap", {31'd0, tx_a}, 32'd0);
        wait_busy_low(0, 60);
        check_idle("after_stream", 8);

        // 4: start pulse during a frame is ignored
        @(posedge clk);
        #1 data_a = 8'h00; start_a = 1'b1; q_a.push_back(8'h00);
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1 data_a = 8'hFF; start_a = 1'b1;
        @(negedge clk);
        check("ignored_busy", {31'd0, busy_a}, 32'd1);
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_busy_low(0, 60);
        check_idle("after_ignored", 30);

        // 5: i_data changed after acceptance does not leak into the frame
        @(posedge clk);
        #1 data_a = 8'hA5; start_a = 1'b1; q_a.push_back(8'hA5);
        @(posedge clk);
        #1 start_a = 1'b0;
        @(posedge clk);
        #1 data_a = 8'h3C;
        wait_busy_low(0, 60);
        check_idle("after_a5", 8);

        // 6: BAUD_DIV=2 streaming 0x00..0x03
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 data_b = 8'(i); start_b = 1'b1; q_b.push_back(8'(i));
            if (i > 0) wait_busy_low(1, 40);
            @(posedge clk);
            #1 acc[i] = cyc;
        end
        start_b = 1'b0;
        for (int i = 1; i < 4; i++) check("div2_period", acc[i] - acc[i-1], 32'd20);
        wait_busy_low(1, 40);
        repeat (10) @(negedge clk);

        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
